// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: funct codes, operand modes,
// multiply/divide FSM states and the EX/MEM bundle with its bubble value.
package ex_pkg;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_AND  = 4'd2;
    localparam logic [3:0] FN_OR   = 4'd3;
    localparam logic [3:0] FN_SLL  = 4'd4;
    localparam logic [3:0] FN_SRL  = 4'd5;
    localparam logic [3:0] FN_SLT  = 4'd6;
    localparam logic [3:0] FN_MUL  = 4'd7;
    localparam logic [3:0] FN_DIV  = 4'd8;
    localparam logic [3:0] FN_MFHI = 4'd9;

    localparam logic [1:0] MODE_RR   = 2'b00;
    localparam logic [1:0] MODE_SEXT = 2'b01;
    localparam logic [1:0] MODE_ZEXT = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam int MULDIV_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    typedef struct packed {
        logic [15:0] alu_result;
        logic [15:0] store_data;
        logic [3:0]  dest_reg;
        logic        wb;
        logic        mem;
    } exmem_t;

    localparam exmem_t EXMEM_BUBBLE = '{alu_result: 16'h0000, store_data: 16'h0000,
                                        dest_reg: 4'h0, wb: 1'b0, mem: 1'b0};

    function automatic logic is_muldiv(input logic [3:0] fn);
        return (fn == FN_MUL) || (fn == FN_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned 16x16 multiply (shift-add) and restoring divide, one bit
// per cycle. Only present in builds with EX_MULDIV_EN defined.
`ifdef EX_MULDIV_EN
module mul_div_unit
    import ex_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        is_div_i,
    input  logic [15:0] op_a_i,
    input  logic [15:0] op_b_i,
    output md_state_e   state_o,
    output logic [15:0] lo_o,
    output logic [15:0] hi_o
);
    localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULDIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [15:0]      hi_q, lo_q, b_q;
    logic             is_div_q;
    logic [16:0]      mul_sum_s, div_shift_s;
    logic [15:0]      div_diff_s, hi_nx_s, lo_nx_s;
    logic             div_ge_s;

    // One iteration: {hi,lo} is the product accumulator or the remainder/quotient pair
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 17'd0);
        div_shift_s = {hi_q, lo_q[15]};
        div_ge_s    = (div_shift_s >= {1'b0, b_q});
        div_diff_s  = div_shift_s[15:0] - b_q;
        if (is_div_q) begin
            hi_nx_s = div_ge_s ? div_diff_s : div_shift_s[15:0];
            lo_nx_s = {lo_q[14:0], div_ge_s};
        end else begin
            hi_nx_s = mul_sum_s[16:1];
            lo_nx_s = {mul_sum_s[0], lo_q[15:1]};
        end
    end

    // Next-state logic; abort always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: begin
                if (start_i && !abort_i) state_d = MD_BUSY;
                else                     state_d = MD_IDLE;
            end
            MD_BUSY: begin
                if (abort_i)                  state_d = MD_IDLE;
                else if (count_q == LAST_CNT) state_d = MD_DONE;
                else                          state_d = MD_BUSY;
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // State, counter and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            count_q  <= '0;
            hi_q     <= 16'h0000;
            lo_q     <= 16'h0000;
            b_q      <= 16'h0000;
            is_div_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == MD_IDLE && state_d == MD_BUSY) begin
                count_q  <= '0;
                hi_q     <= 16'h0000;
                lo_q     <= op_a_i;
                b_q      <= op_b_i;
                is_div_q <= is_div_i;
            end else if (state_q == MD_BUSY) begin
                count_q <= count_q + CNT_W'(1);
                hi_q    <= hi_nx_s;
                lo_q    <= lo_nx_s;
            end
        end
    end

    assign state_o = state_q;
    assign lo_o    = lo_q;
    assign hi_o    = hi_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage producing the EX/MEM register. Define EX_MULDIV_EN to add the
// iterative MUL/DIV unit, HI register and stall; otherwise funct 7/8/9 give 0.
module ex_stage
    import ex_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] outDataOp1,
    input  logic [15:0] outDataOp2,
    input  logic [15:0] outConcatZero,
    input  logic [15:0] outSignExtImd,
    input  logic [3:0]  outIdExOp1,
    input  logic [3:0]  outIdExOp2,
    input  logic        outWB,
    input  logic        outMEM,
    input  logic [1:0]  outEX,
    input  logic [3:0]  funct,
    input  logic        flush,
    output logic [15:0] exAluResult,
    output logic [15:0] exStoreData,
    output logic [3:0]  exDestReg,
    output logic        exWB,
    output logic        exMEM,
    output logic        stall
);
    logic [15:0] b_s, alu_s, md_lo_s, hi_rd_s;
    logic [3:0]  dest_s;
    logic        bubble_s;
    exmem_t      exmem_d, exmem_q;

`ifdef EX_MULDIV_EN
    md_state_e   md_state_s;
    logic [15:0] md_hi_s, hi_q;
    logic        muldiv_req_s;

    assign muldiv_req_s = is_muldiv(funct);

    mul_div_unit #(
        .MULDIV_CYCLES(MULDIV_CYCLES)
    ) u_mul_div (
        .clk     (clk),
        .rst_n   (rst),
        .start_i (muldiv_req_s),
        .abort_i (flush),
        .is_div_i(funct == FN_DIV),
        .op_a_i  (outDataOp1),
        .op_b_i  (b_s),
        .state_o (md_state_s),
        .lo_o    (md_lo_s),
        .hi_o    (md_hi_s)
    );

    assign stall    = rst && ((md_state_s == MD_IDLE && muldiv_req_s) || md_state_s == MD_BUSY);
    assign bubble_s = flush || (md_state_s == MD_IDLE && muldiv_req_s) || (md_state_s == MD_BUSY);
    assign hi_rd_s  = hi_q;

    // HI captures the high half/remainder when a completed op retires unflushed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= 16'h0000;
        end else if (md_state_s == MD_DONE && !flush) begin
            hi_q <= md_hi_s;
        end
    end
`else
    assign stall    = 1'b0;
    assign bubble_s = flush;
    assign md_lo_s  = 16'h0000;
    assign hi_rd_s  = 16'h0000;
`endif

    // Operand B and destination select; reserved mode behaves as R-type
    always_comb begin
        case (outEX)
            MODE_SEXT: begin b_s = outSignExtImd; dest_s = outIdExOp1; end
            MODE_ZEXT: begin b_s = outConcatZero; dest_s = outIdExOp1; end
            default:   begin b_s = outDataOp2;    dest_s = outIdExOp2; end
        endcase
    end

    // Single-cycle ALU plus MUL/DIV/MFHI result routing
    always_comb begin
        case (funct)
            FN_ADD:  alu_s = outDataOp1 + b_s;
            FN_SUB:  alu_s = outDataOp1 - b_s;
            FN_AND:  alu_s = outDataOp1 & b_s;
            FN_OR:   alu_s = outDataOp1 | b_s;
            FN_SLL:  alu_s = outDataOp1 << b_s[3:0];
            FN_SRL:  alu_s = outDataOp1 >> b_s[3:0];
            FN_SLT:  alu_s = ($signed(outDataOp1) < $signed(b_s)) ? 16'h0001 : 16'h0000;
            FN_MUL:  alu_s = md_lo_s;
            FN_DIV:  alu_s = md_lo_s;
            FN_MFHI: alu_s = hi_rd_s;
            default: alu_s = outDataOp1;
        endcase
    end

    // EX/MEM next value: bubble or the current instruction's results
    always_comb begin
        if (bubble_s) begin
            exmem_d = EXMEM_BUBBLE;
        end else begin
            exmem_d = '{alu_result: alu_s, store_data: outDataOp2, dest_reg: dest_s,
                        wb: outWB, mem: outMEM};
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exmem_q <= EXMEM_BUBBLE;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign exAluResult = exmem_q.alu_result;
    assign exStoreData = exmem_q.store_data;
    assign exDestReg   = exmem_q.dest_reg;
    assign exWB        = exmem_q.wb;
    assign exMEM       = exmem_q.mem;

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized bench for ex_stage with an arithmetic reference model;
// the MUL/DIV section follows whether EX_MULDIV_EN is defined.
module tb_ex_stage;

    logic        clk, rst;
    logic [15:0] outDataOp1, outDataOp2, outConcatZero, outSignExtImd;
    logic [3:0]  outIdExOp1, outIdExOp2, funct;
    logic        outWB, outMEM, flush;
    logic [1:0]  outEX;
    logic [15:0] exAluResult, exStoreData;
    logic [3:0]  exDestReg;
    logic        exWB, exMEM, stall;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_hi = 16'h0000;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .outDataOp1(outDataOp1), .outDataOp2(outDataOp2),
        .outConcatZero(outConcatZero), .outSignExtImd(outSignExtImd),
        .outIdExOp1(outIdExOp1), .outIdExOp2(outIdExOp2),
        .outWB(outWB), .outMEM(outMEM), .outEX(outEX), .funct(funct), .flush(flush),
        .exAluResult(exAluResult), .exStoreData(exStoreData), .exDestReg(exDestReg),
        .exWB(exWB), .exMEM(exMEM), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_b(input logic [1:0] md, input logic [15:0] op2,
                                            input logic [15:0] sx, input logic [15:0] zx);
        if (md == 2'd1) return sx;
        if (md == 2'd2) return zx;
        return op2;
    endfunction

    function automatic logic [15:0] model_alu(input logic [3:0] fn, input logic [15:0] a,
                                              input logic [15:0] b, input logic [15:0] hi);
        longint ia, ib, sa, sb, sh;
        ia = longint'(a); ib = longint'(b); sh = ib % 16;
        sa = (ia >= 32768) ? ia - 65536 : ia;
        sb = (ib >= 32768) ? ib - 65536 : ib;
        case (fn)
            4'd0: return 16'((ia + ib) % 65536);
            4'd1: return 16'((ia - ib + 65536) % 65536);
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return 16'((ia * (longint'(1) << sh)) % 65536);
            4'd5: return 16'(ia / (longint'(1) << sh));
            4'd6: return (sa < sb) ? 16'd1 : 16'd0;
`ifdef EX_MULDIV_EN
            4'd7: return 16'((ia * ib) % 65536);
            4'd8: return (ib == 0) ? 16'hFFFF : 16'(ia / ib);
            4'd9: return hi;
`else
            4'd7, 4'd8, 4'd9: return 16'h0000;
`endif
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_exmem(input string tag, input logic [15:0] res, input logic [15:0] st,
                               input logic [3:0] dst, input logic wb, input logic mem);
        check({tag, ".result"}, exAluResult, res);
        check({tag, ".store"}, exStoreData, st);
        check({tag, ".dest"}, 16'(exDestReg), 16'(dst));
        check({tag, ".wb"}, 16'(exWB), 16'(wb));
        check({tag, ".mem"}, 16'(exMEM), 16'(mem));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] fn, input logic [1:0] md, input logic [15:0] a,
                          input logic [15:0] op2, input logic [15:0] sx, input logic [15:0] zx,
                          input logic [3:0] rt, input logic [3:0] rd, input logic wb, input logic mem);
        funct = fn; outEX = md; outDataOp1 = a; outDataOp2 = op2;
        outSignExtImd = sx; outConcatZero = zx; outIdExOp1 = rt; outIdExOp2 = rd;
        outWB = wb; outMEM = mem;
    endtask

    task automatic alu_case(input string tag, input logic [3:0] fn, input logic [1:0] md,
                            input logic [15:0] a, input logic [15:0] op2, input logic [15:0] sx,
                            input logic [15:0] zx, input logic [15:0] exp, input logic [3:0] dst);
        set_in(fn, md, a, op2, sx, zx, 4'd3, 4'd5, 1'b1, 1'b0);
        step();
        check_exmem(tag, exp, op2, dst, 1'b1, 1'b0);
    endtask

`ifdef EX_MULDIV_EN
    // Presents a MUL/DIV and waits (bounded) for stall to drop; returns stalled cycles
    task automatic start_and_wait(input logic [3:0] fn, input logic [15:0] a,
                                  input logic [15:0] b, output int cnt);
        set_in(fn, 2'b00, a, b, 16'h0, 16'h0, 4'd2, 4'd9, 1'b1, 1'b1);
        #1;
        check("md_stall_start", 16'(stall), 16'd1);
        cnt = 0;
        while (stall && cnt < 40) begin
            step();
            cnt++;
            check("md_bubble_wb", 16'(exWB), 16'd0);
            check("md_bubble_res", exAluResult, 16'h0000);
        end
    endtask

    task automatic run_muldiv(input string tag, input logic [3:0] fn, input logic [15:0] a,
                              input logic [15:0] b);
        int          cnt;
        longint      prod;
        logic [15:0] exp_lo, exp_hi;
        if (fn == 4'd7) begin
            prod   = longint'(a) * longint'(b);
            exp_lo = 16'(prod % 65536);
            exp_hi = 16'(prod / 65536);
        end else begin
            exp_lo = (b == 16'd0) ? 16'hFFFF : 16'(a / b);
            exp_hi = (b == 16'd0) ? a : 16'(a % b);
        end
        start_and_wait(fn, a, b, cnt);
        check({tag, ".stall_len"}, 16'(cnt), 16'd17);
        step();
        check_exmem(tag, exp_lo, b, 4'd9, 1'b1, 1'b1);
        ref_hi = exp_hi;
        funct = 4'd9;
        #1;
        check({tag, ".mfhi_nostall"}, 16'(stall), 16'd0);
        step();
        check({tag, ".mfhi"}, exAluResult, ref_hi);
    endtask
`endif

    initial begin
        int          cnt;
        logic [3:0]  fn;
        logic [1:0]  md;
        logic [15:0] exp_res, exp_b;
        logic [3:0]  exp_dst;

        rst = 1'b0; flush = 1'b0;
        set_in(4'd0, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
        #2;
        check_exmem("reset", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        check("reset.stall", 16'(stall), 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        alu_case("add_wrap", 4'd0, 2'b00, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 16'h8000, 4'd5);
        alu_case("add_sext", 4'd0, 2'b01, 16'h0005, 16'h1234, 16'hFFFE, 16'h0, 16'h0003, 4'd3);
        alu_case("or_zext",  4'd3, 2'b10, 16'h0F00, 16'h0000, 16'h0, 16'h00FF, 16'h0FFF, 4'd3);
        alu_case("sub_wrap", 4'd1, 2'b00, 16'h0000, 16'h0001, 16'h0, 16'h0, 16'hFFFF, 4'd5);
        alu_case("slt_neg",  4'd6, 2'b00, 16'h8000, 16'h0001, 16'h0, 16'h0, 16'h0001, 4'd5);
        alu_case("sll_rsvd", 4'd4, 2'b11, 16'h0001, 16'h001F, 16'h0, 16'h0, 16'h8000, 4'd5);
        alu_case("pass_f15", 4'd15, 2'b00, 16'hBEEF, 16'h0001, 16'h0, 16'h0, 16'hBEEF, 4'd5);

        // Asynchronous reset clears a non-zero EX/MEM immediately
        alu_case("pre_rst", 4'd0, 2'b00, 16'h1111, 16'h2222, 16'h0, 16'h0, 16'h3333, 4'd5);
        #2 rst = 1'b0;
        #1;
        check_exmem("async_rst", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        ref_hi = 16'h0000;

`ifdef EX_MULDIV_EN
        run_muldiv("mul", 4'd7, 16'h0100, 16'h0300);

        // Flush during BUSY aborts without touching HI
        set_in(4'd7, 2'b00, 16'h0003, 16'h0005, 16'h0, 16'h0, 4'd2, 4'd9, 1'b1, 1'b0);
        repeat (5) step();
        check("flush_busy.stall", 16'(stall), 16'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_exmem("flush_busy", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        funct = 4'd0;
        #1;
        check("flush_busy.stall_low", 16'(stall), 16'd0);
        step();
        check("flush_busy.add", exAluResult, 16'h0008);
        funct = 4'd9;
        step();
        check("flush_busy.mfhi", exAluResult, ref_hi);

        // Flush coinciding with DONE wins; HI not written
        start_and_wait(4'd7, 16'hFFFF, 16'hFFFF, cnt);
        check("flush_done.len", 16'(cnt), 16'd17);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_exmem("flush_done", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        funct = 4'd9;
        step();
        check("flush_done.mfhi", exAluResult, ref_hi);

        // Reset while BUSY discards the operation and clears HI
        set_in(4'd7, 2'b00, 16'h0007, 16'h0009, 16'h0, 16'h0, 4'd2, 4'd9, 1'b1, 1'b0);
        repeat (3) step();
        #2 rst = 1'b0;
        #1;
        check("rst_busy.stall", 16'(stall), 16'd0);
        check_exmem("rst_busy", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        funct = 4'd0;
        #1 rst = 1'b1;
        #1;
        check("rst_busy.idle", 16'(stall), 16'd0);
        funct = 4'd9;
        step();
        check("rst_busy.mfhi", exAluResult, 16'h0000);
        ref_hi = 16'h0000;

        run_muldiv("div", 4'd8, 16'd100, 16'd7);
        run_muldiv("div0", 4'd8, 16'h1234, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            run_muldiv("md_rnd", 4'(7 + (k % 2)), 16'($urandom),
                       (k == 3) ? 16'h0000 : 16'($urandom_range(1, 65535)));
        end
`else
        set_in(4'd7, 2'b00, 16'h0100, 16'h0300, 16'h0, 16'h0, 4'd2, 4'd9, 1'b1, 1'b0);
        #1;
        check("nomd_mul.stall", 16'(stall), 16'd0);
        step();
        check_exmem("nomd_mul", 16'h0000, 16'h0300, 4'd9, 1'b1, 1'b0);
        alu_case("nomd_div", 4'd8, 2'b00, 16'd100, 16'd7, 16'h0, 16'h0, 16'h0000, 4'd5);
        alu_case("nomd_mfhi", 4'd9, 2'b00, 16'hAAAA, 16'd7, 16'h0, 16'h0, 16'h0000, 4'd5);
`endif

        for (int i = 0; i < 150; i++) begin
            fn = 4'($urandom_range(0, 15));
`ifdef EX_MULDIV_EN
            if (fn == 4'd7 || fn == 4'd8) fn = 4'd9;
`endif
            md = 2'($urandom_range(0, 3));
            set_in(fn, md, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            flush = ($urandom_range(0, 7) == 0);
            exp_b   = model_b(md, outDataOp2, outSignExtImd, outConcatZero);
            exp_res = model_alu(fn, outDataOp1, exp_b, ref_hi);
            exp_dst = (md == 2'd1 || md == 2'd2) ? outIdExOp1 : outIdExOp2;
            #1;
            check("rnd.stall", 16'(stall), 16'd0);
            step();
            if (flush) check_exmem("rnd_flush", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
            else       check_exmem("rnd", exp_res, outDataOp2, exp_dst, outWB, outMEM);
            flush = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
